// File: rtl/tdc_seq_pkg.sv
// Shared types and defaults for the TDC measurement sequencer.
package tdc_seq_pkg;

    // Default number of cycles allowed between the capture pulse and the done pulse
    // when the TDC never raises val_out.
    localparam int TIMEOUT_DEFAULT = 16;

    // Width of a Hamming-weight result for an N-tap delay line (0..N inclusive).
    function automatic int hw_width(input int n);
        return $clog2(n) + 1;
    endfunction

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_DELAY,
        S_CAPTURE,
        S_WAIT_VAL,
        S_ACCUM,
        S_DONE
    } seq_state_t;

endpackage

// File: rtl/tdc_seq_stats.sv
// Running statistics over the Hamming-weight results of one batch.
module tdc_seq_stats
    import tdc_seq_pkg::*;
#(
    parameter int HW_W  = 7,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  acc_en,
    input  logic [HW_W-1:0]       hw,
    output logic [CNT_W-1:0]      n_done,
    output logic [HW_W+CNT_W-1:0] sum,
    output logic [HW_W-1:0]       hw_min,
    output logic [HW_W-1:0]       hw_max
);

    // Clear to the empty-batch values, otherwise fold in one sample per enable.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            n_done <= '0;
            sum    <= '0;
            hw_min <= '1;
            hw_max <= '0;
        end else if (acc_en) begin
            n_done <= n_done + 1'b1;
            sum    <= sum + {{CNT_W{1'b0}}, hw};
            if (hw < hw_min) hw_min <= hw;
            if (hw > hw_max) hw_max <= hw;
        end
    end

endmodule

// File: rtl/tdc_sequencer.sv
// Batch controller for tdc_top: issues launch/capture pulse pairs with a
// programmable spacing, collects the Hamming-weight results and keeps
// sum/min/max over the batch.
module tdc_sequencer
    import tdc_seq_pkg::*;
#(
    parameter int N       = 64,
    parameter int HW_W    = hw_width(N),
    parameter int DLY_W   = 8,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DLY_W-1:0]      cfg_delay,
    input  logic [CNT_W-1:0]      cfg_count,
    input  logic                  cfg_src,
    input  logic                  cfg_bypass,
    output logic                  clk_launch,
    output logic                  clk_capture,
    output logic                  pg_src,
    output logic                  pg_bypass,
    output logic                  pg_in,
    output logic                  pg_tog,
    output logic                  val_in,
    input  logic [HW_W-1:0]       hw,
    input  logic                  val_out,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err,
    output logic [CNT_W-1:0]      n_done,
    output logic [HW_W+CNT_W-1:0] sum,
    output logic [HW_W-1:0]       hw_min,
    output logic [HW_W-1:0]       hw_max
);

    // The deadline is counted from the capture pulse: capture cycle, WAIT_VAL
    // cycles, the DONE state and the registered done pulse together span TIMEOUT
    // cycles, so WAIT_VAL gets TIMEOUT-2 cycles (counter 0..TIMEOUT-3).
    localparam int                WAIT_W    = $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 3);

    seq_state_t        state, next_state;
    logic [DLY_W-1:0]  dly_q, dly_cnt;
    logic [CNT_W-1:0]  cnt_q;
    logic              src_q, byp_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic [HW_W-1:0]   hw_q;

    logic accept, last_meas, wait_expire;
    logic launch_n, capture_n, pg_in_n, val_in_n, busy_n, done_n;
    logic pg_src_n, pg_bypass_n, pg_tog_n;

    // A start is taken only from IDLE, and not in the cycle the previous
    // batch's done pulse is visible.
    assign accept      = (state == S_IDLE) && start && !done;
    assign last_meas   = (n_done + 1'b1) == cnt_q;
    assign wait_expire = (wait_cnt == WAIT_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Next-state decode.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept) next_state = (cfg_count == '0) ? S_DONE : S_LAUNCH;
            end
            S_LAUNCH:   next_state = (dly_q != '0) ? S_DELAY : S_CAPTURE;
            S_DELAY:    if (dly_cnt == '0) next_state = S_CAPTURE;
            S_CAPTURE:  next_state = S_WAIT_VAL;
            S_WAIT_VAL: begin
                if (val_out)          next_state = S_ACCUM;
                else if (wait_expire) next_state = S_DONE;
            end
            S_ACCUM:    next_state = last_meas ? S_DONE : S_LAUNCH;
            S_DONE:     next_state = S_IDLE;
            default:    next_state = S_IDLE;
        endcase
    end

    // Output decode: pin values for the upcoming state, registered below so the
    // pulses line up with the state they belong to. done is taken from the
    // DONE state itself, so it appears together with busy falling.
    always_comb begin
        launch_n    = (next_state == S_LAUNCH);
        capture_n   = (next_state == S_CAPTURE);
        pg_in_n     = (next_state == S_LAUNCH) || (next_state == S_DELAY);
        // val_in qualifies the whole launch..capture window and drops while
        // the result is awaited.
        val_in_n    = (next_state == S_LAUNCH) || (next_state == S_DELAY) ||
                      (next_state == S_CAPTURE);
        busy_n      = (next_state != S_IDLE);
        done_n      = (state == S_DONE);
        pg_src_n    = busy_n && (accept ? cfg_src    : src_q);
        pg_bypass_n = busy_n && (accept ? cfg_bypass : byp_q);
        // Toggle starts from 0 each batch and flips on every launch.
        pg_tog_n    = busy_n && (pg_tog ^ launch_n);
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_launch  <= 1'b0;
            clk_capture <= 1'b0;
            pg_in       <= 1'b0;
            val_in      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pg_src      <= 1'b0;
            pg_bypass   <= 1'b0;
            pg_tog      <= 1'b0;
        end else begin
            clk_launch  <= launch_n;
            clk_capture <= capture_n;
            pg_in       <= pg_in_n;
            val_in      <= val_in_n;
            busy        <= busy_n;
            done        <= done_n;
            pg_src      <= pg_src_n;
            pg_bypass   <= pg_bypass_n;
            pg_tog      <= pg_tog_n;
        end
    end

    // Config latch, delay/wait counters, result capture and the sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            dly_q       <= '0;
            cnt_q       <= '0;
            src_q       <= 1'b0;
            byp_q       <= 1'b0;
            dly_cnt     <= '0;
            wait_cnt    <= '0;
            hw_q        <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (accept) begin
                dly_q       <= cfg_delay;
                cnt_q       <= cfg_count;
                src_q       <= cfg_src;
                byp_q       <= cfg_bypass;
                timeout_err <= 1'b0;
            end
            case (state)
                S_LAUNCH:  dly_cnt  <= dly_q - 1'b1;
                S_DELAY:   dly_cnt  <= dly_cnt - 1'b1;
                S_CAPTURE: wait_cnt <= '0;
                S_WAIT_VAL: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (val_out)          hw_q        <= hw;
                    else if (wait_expire) timeout_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    tdc_seq_stats #(
        .HW_W  (HW_W),
        .CNT_W (CNT_W)
    ) u_stats (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept),
        .acc_en (state == S_ACCUM),
        .hw     (hw_q),
        .n_done (n_done),
        .sum    (sum),
        .hw_min (hw_min),
        .hw_max (hw_max)
    );

endmodule

// File: tb/tb_tdc_sequencer.sv
// Directed bench for tdc_sequencer with a small TDC response model.
module tb_tdc_sequencer;

    localparam int N = 64, HW_W = 7, DLY_W = 8, CNT_W = 8, TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst, start, cfg_src, cfg_bypass;
    logic [DLY_W-1:0] cfg_delay;
    logic [CNT_W-1:0] cfg_count;
    logic clk_launch, clk_capture, pg_src, pg_bypass, pg_in, pg_tog, val_in;
    logic [HW_W-1:0] hw = '0;
    logic val_out = 1'b0;
    logic busy, done, timeout_err;
    logic [CNT_W-1:0] n_done;
    logic [HW_W+CNT_W-1:0] sum;
    logic [HW_W-1:0] hw_min, hw_max;

    tdc_sequencer #(.N(N), .HW_W(HW_W), .DLY_W(DLY_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_delay(cfg_delay), .cfg_count(cfg_count),
        .cfg_src(cfg_src), .cfg_bypass(cfg_bypass), .clk_launch(clk_launch),
        .clk_capture(clk_capture), .pg_src(pg_src), .pg_bypass(pg_bypass), .pg_in(pg_in),
        .pg_tog(pg_tog), .val_in(val_in), .hw(hw), .val_out(val_out), .busy(busy),
        .done(done), .timeout_err(timeout_err), .n_done(n_done), .sum(sum),
        .hw_min(hw_min), .hw_max(hw_max)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // TDC model: answers val_out 2 cycles after each capture pulse with the next table entry.
    logic [HW_W-1:0] hw_tab [4];
    logic model_en;
    int idx = 0;
    logic [1:0] cap_pipe = 2'b00;
    always @(posedge clk) begin
        #1;
        if (model_en && cap_pipe[1] && idx < 4) begin
            val_out = 1'b1;
            hw      = hw_tab[idx];
            idx++;
        end else begin
            val_out = 1'b0;
            hw      = 7'h55;
        end
        cap_pipe = {cap_pipe[0], clk_capture};
        if (!busy) idx = 0;
    end

    // Pulse monitor: counts events and checks launch-to-capture spacing.
    int n_launch = 0, n_capture = 0, n_donep = 0, n_tog = 0, n_bad_space = 0;
    int t_launch = 0, t_cap = 0, exp_space;
    logic prev_tog = 1'b0;
    always @(posedge clk) begin
        #1;
        if (clk_launch) begin n_launch++; t_launch = cyc; end
        if (clk_capture) begin
            n_capture++;
            t_cap = cyc;
            if (cyc - t_launch != exp_space) n_bad_space++;
        end
        if (done) n_donep++;
        if (pg_tog !== prev_tog) n_tog++;
        prev_tog = pg_tog;
    end

    int n_chk = 0, n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_batch(input int dly, input int cnt, input logic src, input logic byp,
                               output int t0);
        cfg_delay  = DLY_W'(dly);
        cfg_count  = CNT_W'(cnt);
        cfg_src    = src;
        cfg_bypass = byp;
        start      = 1'b1;
        t0         = cyc;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_done(input int lim, output int t);
        t = -1;
        for (int k = 0; k < lim; k++) begin
            tick();
            if (done === 1'b1) begin
                t = cyc;
                break;
            end
        end
        check("done_seen", 32'(t >= 0), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0, td, sl, sc, sd, sb, st;
        rst = 1'b1; start = 1'b0; cfg_delay = '0; cfg_count = '0;
        cfg_src = 1'b0; cfg_bypass = 1'b0; model_en = 1'b1; exp_space = 4;
        hw_tab = '{7'd0, 7'd0, 7'd0, 7'd0};
        tick(); tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_launch", 32'(clk_launch), 0);
        check("rst_pg_in", 32'(pg_in), 0);
        check("rst_n_done", 32'(n_done), 0);
        check("rst_sum", 32'(sum), 0);
        check("rst_min", 32'(hw_min), 127);
        check("rst_max", 32'(hw_max), 0);
        check("rst_tmo", 32'(timeout_err), 0);
        rst = 1'b0;
        tick();

        // Basic batch: delay 3, count 4.
        exp_space = 4;
        hw_tab = '{7'd20, 7'd22, 7'd21, 7'd23};
        sl = n_launch; sc = n_capture; sd = n_donep; sb = n_bad_space;
        start_batch(3, 4, 1'b1, 1'b0, t0);
        check("b_busy", 32'(busy), 1);
        check("b_launch", 32'(clk_launch), 1);
        check("b_pg_src", 32'(pg_src), 1);
        check("b_pg_byp", 32'(pg_bypass), 0);
        check("b_pg_in", 32'(pg_in), 1);
        check("b_val_in", 32'(val_in), 1);
        check("b_pg_tog", 32'(pg_tog), 1);
        wait_done(100, td);
        check("b_len", 32'(td - t0), 34);
        check("b_busy_end", 32'(busy), 0);
        check("b_sum", 32'(sum), 86);
        check("b_min", 32'(hw_min), 20);
        check("b_max", 32'(hw_max), 23);
        check("b_n_done", 32'(n_done), 4);
        check("b_tmo", 32'(timeout_err), 0);
        tick();
        check("b_done_1cyc", 32'(done), 0);
        check("b_pg_src_idle", 32'(pg_src), 0);
        check("b_launches", 32'(n_launch - sl), 4);
        check("b_captures", 32'(n_capture - sc), 4);
        check("b_spacing", 32'(n_bad_space - sb), 0);
        check("b_done_pulses", 32'(n_donep - sd), 1);

        // Zero count.
        sl = n_launch;
        start_batch(0, 0, 1'b1, 1'b1, t0);
        check("z_busy", 32'(busy), 1);
        check("z_done_early", 32'(done), 0);
        check("z_pg_byp", 32'(pg_bypass), 1);
        tick();
        check("z_done", 32'(done), 1);
        check("z_busy_end", 32'(busy), 0);
        check("z_sum", 32'(sum), 0);
        check("z_min", 32'(hw_min), 127);
        check("z_max", 32'(hw_max), 0);
        check("z_n_done", 32'(n_done), 0);
        tick();
        check("z_launches", 32'(n_launch - sl), 0);

        // Timeout: model silent.
        model_en = 1'b0; exp_space = 3;
        sl = n_launch;
        start_batch(2, 3, 1'b0, 1'b0, t0);
        wait_done(60, td);
        check("t_cap_to_done", 32'(td - t_cap), 16);
        check("t_len", 32'(td - t0), 20);
        check("t_tmo", 32'(timeout_err), 1);
        check("t_n_done", 32'(n_done), 0);
        check("t_sum", 32'(sum), 0);
        tick();
        check("t_tmo_sticky", 32'(timeout_err), 1);
        check("t_launches", 32'(n_launch - sl), 1);
        model_en = 1'b1;

        // Zero delay with pg_tog.
        exp_space = 1;
        hw_tab = '{7'd64, 7'd0, 7'd0, 7'd0};
        st = n_tog; sb = n_bad_space;
        start_batch(0, 2, 1'b0, 1'b0, t0);
        check("d0_tmo_clr", 32'(timeout_err), 0);
        check("d0_tog1", 32'(pg_tog), 1);
        wait_done(60, td);
        check("d0_len", 32'(td - t0), 12);
        check("d0_sum", 32'(sum), 64);
        check("d0_min", 32'(hw_min), 0);
        check("d0_max", 32'(hw_max), 64);
        check("d0_n_done", 32'(n_done), 2);
        check("d0_tog_end", 32'(pg_tog), 0);
        tick();
        check("d0_toggles", 32'(n_tog - st), 2);
        check("d0_spacing", 32'(n_bad_space - sb), 0);

        // Reset during DELAY of measurement 2.
        exp_space = 6;
        hw_tab = '{7'd30, 7'd40, 7'd50, 7'd0};
        start_batch(5, 3, 1'b1, 1'b1, t0);
        repeat (12) tick();
        check("r_in_delay_pg_in", 32'(pg_in), 1);
        check("r_in_delay_launch", 32'(clk_launch), 0);
        check("r_in_delay_n", 32'(n_done), 1);
        check("r_in_delay_sum", 32'(sum), 30);
        rst = 1'b1;
        tick();
        check("r_busy", 32'(busy), 0);
        check("r_pg_in", 32'(pg_in), 0);
        check("r_val_in", 32'(val_in), 0);
        check("r_pg_src", 32'(pg_src), 0);
        check("r_pg_byp", 32'(pg_bypass), 0);
        check("r_n_done", 32'(n_done), 0);
        check("r_sum", 32'(sum), 0);
        check("r_min", 32'(hw_min), 127);
        check("r_max", 32'(hw_max), 0);
        rst = 1'b0;
        tick();
        exp_space = 2;
        hw_tab = '{7'd5, 7'd9, 7'd0, 7'd0};
        sb = n_bad_space;
        start_batch(1, 2, 1'b0, 1'b0, t0);
        wait_done(60, td);
        check("r2_len", 32'(td - t0), 14);
        check("r2_sum", 32'(sum), 14);
        check("r2_min", 32'(hw_min), 5);
        check("r2_max", 32'(hw_max), 9);
        check("r2_n_done", 32'(n_done), 2);
        tick();
        check("r2_spacing", 32'(n_bad_space - sb), 0);

        // Start while busy, and start during the done cycle, are both ignored.
        exp_space = 3;
        hw_tab = '{7'd10, 7'd12, 7'd0, 7'd0};
        sl = n_launch; sb = n_bad_space;
        start_batch(2, 2, 1'b0, 1'b0, t0);
        repeat (4) tick();
        cfg_delay = 8'd7; cfg_count = 8'd5; start = 1'b1;
        tick();
        start = 1'b0;
        check("sb_busy", 32'(busy), 1);
        wait_done(80, td);
        check("sb_len", 32'(td - t0), 16);
        check("sb_sum", 32'(sum), 22);
        check("sb_n_done", 32'(n_done), 2);
        check("sb_min", 32'(hw_min), 10);
        check("sb_max", 32'(hw_max), 12);
        cfg_count = 8'd1; cfg_delay = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check("sd_busy", 32'(busy), 0);
        check("sd_launch", 32'(clk_launch), 0);
        tick();
        check("sd_busy2", 32'(busy), 0);
        check("sb_launches", 32'(n_launch - sl), 2);
        check("sb_spacing", 32'(n_bad_space - sb), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
